prefix_sum_seq: RTL and testbench
=================================

Name: prefix_sum_seq

Overview:
- Sequencer that streams a wide sparsity mask through a single combinational prefix-sum unit, one PS_SIZE-bit chunk per cycle.
- Adds a running base offset so each chunk's outputs are global inclusive indices into the compressed operand buffer.
- Sits between the sparse-operand loader, which supplies masks, and the gather/address-generation stage, which consumes indices.
- Uses valid/ready handshakes on both sides.

Parameters:
- PS_SIZE, default `PREFIX_SUM_SIZE (32): chunk width, and the input width of the prefix-sum unit.
- CHUNKS, default 4: number of chunks per mask; CHUNKS ≥ 1.
- CNT_W, default $clog2(CHUNKS*PS_SIZE)+1: width of every index and count output.

Ports:
- clk_i input 1: clock.
- rst_i input 1: synchronous, active-high reset.
- mask_valid_i input 1: mask available.
- mask_ready_o output 1: sequencer can accept a mask.
- mask_i input CHUNKS*PS_SIZE: sparsity mask; chunk k = mask_i[k*PS_SIZE +: PS_SIZE].
- out_valid_o output 1: output register holds a chunk result.
- out_ready_i input 1: consumer accepts the chunk result.
- out_idx_o output PS_SIZE x CNT_W: global inclusive index per bit position 1..PS_SIZE.
- out_chunk_o output $clog2(CHUNKS)+1: number of the chunk currently presented.
- out_last_o output 1: presented chunk is chunk CHUNKS-1.
- total_o output CNT_W: popcount of the most recently completed mask.
- busy_o output 1: state is RUN, or out_valid_o is high.

Behaviour:
- Reset (clk_i edge with rst_i=1): state=IDLE; mask_reg, chunk_cnt, base, out_idx_o, out_chunk_o, out_last_o and total_o all cleared to 0; out_valid_o=0. mask_ready_o=1 in the cycle after reset.
- Reset mid-operation: any captured mask and any pending output are discarded with no further outputs; the next mask starts from base 0.
- Prefix-sum mapping: bit j (1-based) of the prefix-sum unit input = mask bit k*PS_SIZE + j - 1. The unit output ps[j] = popcount of chunk bits 1..j.
- FSM, two states:
  - IDLE: mask_ready_o=1. On mask_valid_i & mask_ready_o, capture mask_i into mask_reg, set chunk_cnt=0 and base=0, go to RUN. mask_i is ignored at all other times.
  - RUN: mask_ready_o=0. A load happens on any edge where (!out_valid_o | out_ready_i).
- Load in RUN:
  - out_idx_o[j] ← base + ps[j]; out_chunk_o ← chunk_cnt; out_last_o ← (chunk_cnt==CHUNKS-1); out_valid_o ← 1.
  - base ← base + ps[PS_SIZE]; chunk_cnt ← chunk_cnt + 1.
  - On the load of the last chunk: total_o ← base + ps[PS_SIZE], and go to IDLE.
- Output consume without load: when out_valid_o & out_ready_i and no load occurs on that edge (IDLE, or RUN stall impossible), out_valid_o ← 0. Other output fields hold their values.
- Stall rule: while out_valid_o & !out_ready_i, every output is held stable and chunk_cnt and base do not advance. No chunk is ever dropped or duplicated.
- Latency:
  - Mask accepted on edge E0 → chunk 0 loaded on edge E1.
  - With out_ready_i held high, chunk k is loaded on edge E1+k.
  - mask_ready_o rises in the cycle after the last-chunk load. A new mask may be accepted there while the last chunk is still being presented.
  - Steady-state throughput: one mask per CHUNKS+1 cycles.
- Overlap: a new mask's chunk 0 loads only when the output slot is free or being consumed. total_o updates only on a last-chunk load.
- Arithmetic: unsigned. CNT_W is sized so the maximum value CHUNKS*PS_SIZE never overflows; no wrap is possible.
- CHUNKS=1: each accepted mask produces one output with out_last_o=1.

Test Plan (PS_SIZE=32, CHUNKS=4, CNT_W=8):
1. All-ones mask, out_ready_i=1 → four consecutive valid cycles.
   - Chunk k: out_idx_o[j] = 32k + j, so chunk 3 idx[32] = 128.
   - out_last_o high only on chunk 3; total_o = 128 after the last load.
2. Mask with only bits 0 and 127 set → chunks 0–2: all idx = 1. Chunk 3: idx[1..31] = 1, idx[32] = 2. total_o = 2.
3. Mask 0x0000_00FF repeated in each chunk; out_ready_i low for 3 cycles while chunk 1 is presented → chunk 1 held stable (idx[8..32] = 16). Then chunk 2 (idx[32] = 24) and chunk 3 (idx[32] = 32) follow with no gap or repeat.
4. mask_valid_i held high with two masks (all-ones, then all-zero) → second mask accepted in the cycle after the first mask's chunk 3 load. Its chunks are all-zero with base restarted at 0; total_o goes 128 then 0.
5. rst_i asserted for one cycle while chunk 1 is presented → next cycle: out_valid_o=0, mask_ready_o=1, total_o=0, busy_o=0. A subsequent all-ones mask yields chunk 0 idx[1] = 1.
6. All-zero mask → four outputs, all idx = 0, out_chunk_o = 0, 1, 2, 3, out_last_o on chunk 3, total_o = 0.

Source files
------------

// File: rtl/prefix_sum_seq.sv
// prefix_sum_seq: streams a wide sparsity mask through one prefix-sum
// unit, one chunk per cycle, emitting global inclusive indices.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 32
`endif

module prefix_sum_seq #(
  parameter int PS_SIZE = `PREFIX_SUM_SIZE,
  parameter int CHUNKS  = 4,
  parameter int CNT_W   = $clog2(CHUNKS*PS_SIZE)+1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mask_valid_i,
  output logic                       mask_ready_o,
  input  logic [CHUNKS*PS_SIZE-1:0]  mask_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PS_SIZE*CNT_W-1:0]   out_idx_o,
  output logic [$clog2(CHUNKS):0]    out_chunk_o,
  output logic                       out_last_o,
  output logic [CNT_W-1:0]           total_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(CHUNKS)+1;
  localparam int MW = CHUNKS*PS_SIZE;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [MW-1:0]          mask_q, mask_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]       base_q, base_d;
  logic [PS_SIZE*CNT_W-1:0] idx_q, idx_d;
  logic [CW-1:0]          chunk_q, chunk_d;
  logic                   last_q, last_d;
  logic                   vld_q, vld_d;
  logic [CNT_W-1:0]       total_q, total_d;

  logic                   accept;
  logic                   load;
  logic                   is_last;
  logic [PS_SIZE-1:0]     chunk;
  logic [CNT_W-1:0]       ps [0:PS_SIZE];

  // The mask register shifts down, so the live chunk is always at the LSBs
  assign chunk   = mask_q[PS_SIZE-1:0];
  assign is_last = (cnt_q == CW'(CHUNKS-1));
  assign accept  = mask_valid_i & mask_ready_o;
  assign load    = (state_q == RUN) & (~vld_q | out_ready_i);

  assign out_valid_o = vld_q;
  assign out_idx_o   = idx_q;
  assign out_chunk_o = chunk_q;
  assign out_last_o  = last_q;
  assign total_o     = total_q;
  assign busy_o      = (state_q == RUN) | vld_q;

  // Combinational inclusive prefix sum of the live chunk
  always_comb begin
    ps[0] = '0;
    for (int j = 1; j <= PS_SIZE; j++) begin
      ps[j] = ps[j-1] + CNT_W'(chunk[j-1]);
    end
  end

  // FSM next state and mask-side handshake
  always_comb begin
    state_d      = state_q;
    mask_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_ready_o = 1'b1;
        if (mask_valid_i) state_d = RUN;
      end
      RUN: begin
        if (load && is_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: capture, chunk load, output consume
  always_comb begin
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    idx_d   = idx_q;
    chunk_d = chunk_q;
    last_d  = last_q;
    vld_d   = vld_q;
    total_d = total_q;
    if (accept) begin
      mask_d = mask_i;
      cnt_d  = '0;
      base_d = '0;
    end
    if (load) begin
      mask_d  = mask_q >> PS_SIZE;
      cnt_d   = cnt_q + CW'(1);
      base_d  = base_q + ps[PS_SIZE];
      chunk_d = cnt_q;
      last_d  = is_last;
      vld_d   = 1'b1;
      for (int j = 1; j <= PS_SIZE; j++) begin
        idx_d[(j-1)*CNT_W +: CNT_W] = base_q + ps[j];
      end
      if (is_last) total_d = base_q + ps[PS_SIZE];
    end else if (vld_q && out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      chunk_q <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      total_q <= '0;
    end else begin
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      chunk_q <= chunk_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      total_q <= total_d;
    end
  end

endmodule

// File: tb/tb_prefix_sum_seq.sv
// tb_prefix_sum_seq: directed vectors for prefix_sum_seq
// (PS_SIZE=32, CHUNKS=4, CNT_W=8).
module tb_prefix_sum_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         mvld;
  logic         mrdy;
  logic [127:0] mask;
  logic         ovld;
  logic         ordy;
  logic [255:0] oidx;
  logic [2:0]   ochunk;
  logic         olast;
  logic [7:0]   total;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prefix_sum_seq #(
    .PS_SIZE(32),
    .CHUNKS (4),
    .CNT_W  (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mask_valid_i(mvld),
    .mask_ready_o(mrdy),
    .mask_i      (mask),
    .out_valid_o (ovld),
    .out_ready_i (ordy),
    .out_idx_o   (oidx),
    .out_chunk_o (ochunk),
    .out_last_o  (olast),
    .total_o     (total),
    .busy_o      (busy)
  );

  function automatic int idx(int j);
    return int'(oidx[(j-1)*8 +: 8]);
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Present a mask until accepted; returns just after the accept edge
  task automatic send(logic [127:0] m, bit hold);
    bit rdy;
    int n;
    mask = m;
    mvld = 1'b1;
    n = 0;
    do begin
      rdy = mrdy;
      nxt();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("accept_timeout", 0, 1);
    if (!hold) mvld = 1'b0;
  endtask

  // Check a presented chunk at bit positions 1, 8, 31, 32
  task automatic ck(string t, int c, int i1, int i8, int i31, int i32);
    chk({t, "_vld"}, int'(ovld), 1);
    chk({t, "_chunk"}, int'(ochunk), c);
    chk({t, "_last"}, int'(olast), (c == 3) ? 1 : 0);
    chk({t, "_i1"}, idx(1), i1);
    chk({t, "_i8"}, idx(8), i8);
    chk({t, "_i31"}, idx(31), i31);
    chk({t, "_i32"}, idx(32), i32);
  endtask

  initial begin
    rst  = 1'b1;
    mvld = 1'b0;
    mask = '0;
    ordy = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    chk("rst_vld", int'(ovld), 0);
    chk("rst_mrdy", int'(mrdy), 1);
    chk("rst_total", int'(total), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_chunk", int'(ochunk), 0);
    chk("rst_idx32", idx(32), 0);

    // 1: all ones
    send({128{1'b1}}, 0);
    chk("t1_mrdy_run", int'(mrdy), 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      ck("t1", k, 32*k+1, 32*k+8, 32*k+31, 32*k+32);
    end
    chk("t1_total", int'(total), 128);
    chk("t1_mrdy", int'(mrdy), 1);
    nxt();
    chk("t1_drain", int'(ovld), 0);
    chk("t1_busy", int'(busy), 0);

    // 2: bits 0 and 127
    send({1'b1, 126'b0, 1'b1}, 0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      ck("t2", k, 1, 1, 1, 1);
    end
    nxt();
    ck("t2", 3, 1, 1, 1, 2);
    chk("t2_total", int'(total), 2);
    nxt();

    // 3: 0xFF per chunk with a 3-cycle stall on chunk 1
    send({4{32'h0000_00FF}}, 0);
    nxt();
    ck("t3", 0, 1, 8, 8, 8);
    nxt();
    ck("t3_c1", 1, 9, 16, 16, 16);
    ordy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      nxt();
      ck("t3_stall", 1, 9, 16, 16, 16);
    end
    ordy = 1'b1;
    nxt();
    ck("t3", 2, 17, 24, 24, 24);
    nxt();
    ck("t3", 3, 25, 32, 32, 32);
    chk("t3_total", int'(total), 32);
    nxt();
    chk("t3_drain", int'(ovld), 0);

    // 4: back-to-back masks with mask_valid held high
    send({128{1'b1}}, 1);
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      ck("t4a", k, 32*k+1, 32*k+8, 32*k+31, 32*k+32);
    end
    chk("t4_total_a", int'(total), 128);
    chk("t4_mrdy", int'(mrdy), 1);
    nxt();
    chk("t4_acc_mrdy", int'(mrdy), 0);
    chk("t4_acc_busy", int'(busy), 1);
    chk("t4_gap_vld", int'(ovld), 0);
    mvld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      ck("t4b", k, 0, 0, 0, 0);
      if (k < 3) chk("t4b_total_hold", int'(total), 128);
    end
    chk("t4_total_b", int'(total), 0);
    nxt();

    // 5: reset while chunk 1 is presented
    send({128{1'b1}}, 0);
    nxt();
    nxt();
    ck("t5_pre", 1, 33, 40, 63, 64);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("t5_vld", int'(ovld), 0);
    chk("t5_mrdy", int'(mrdy), 1);
    chk("t5_total", int'(total), 0);
    chk("t5_busy", int'(busy), 0);
    nxt();
    chk("t5_quiet", int'(ovld), 0);
    send({128{1'b1}}, 0);
    nxt();
    ck("t5_new", 0, 1, 8, 31, 32);
    for (int k = 1; k < 4; k++) nxt();
    ck("t5_end", 3, 97, 104, 127, 128);
    chk("t5_total_end", int'(total), 128);
    nxt();

    // 6: all zero
    send('0, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      ck("t6", k, 0, 0, 0, 0);
    end
    chk("t6_total", int'(total), 0);
    nxt();
    chk("t6_drain", int'(ovld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
